// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared definitions for the AES BRAM word-read engine:
//               FSM state encoding, default address map, error read data.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    // FSM state encoding
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_issue = 3'd1;
    localparam logic [2:0] c_st_wait  = 3'd2;
    localparam logic [2:0] c_st_done  = 3'd3;
    localparam logic [2:0] c_st_rtz   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = c_st_idle,
        ST_ISSUE = c_st_issue,
        ST_WAIT  = c_st_wait,
        ST_DONE  = c_st_done,
        ST_RTZ   = c_st_rtz
    } state_t;

    // Default address map
    localparam logic [31:0] c_def_base_addr   = 32'h0000_0000;
    localparam int          c_def_depth_words = 1024;

    // Word returned on a rejected (misaligned / out-of-range) read
    localparam logic [31:0] c_err_data = 32'h0000_0000;

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_addr_check.sv
`default_nettype none
// ============================================================================
// Module      : aes_addr_check
// Description : Combinational byte-address to BRAM word-index translation with
//               alignment and range checking.
// Ports       : i_addr  - byte address
//               o_idx   - BRAM word index (off[IDX_W+1:2])
//               o_err   - address misaligned or outside the BRAM window
// Revision    : 1.0 - initial release
// ============================================================================
module aes_addr_check #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          IDX_W       = 10
) (
    input  logic [31:0]      i_addr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_err
);

    localparam logic [31:0] c_depth = 32'(DEPTH_WORDS);

    logic [31:0] w_off;
    logic [31:0] w_word;

    // Wrapping subtraction: addresses below BASE_ADDR become huge offsets and
    // therefore fail the range test without a separate lower-bound compare.
    assign w_off  = i_addr - BASE_ADDR;
    assign w_word = w_off >> 2;

    assign o_idx  = w_word[IDX_W-1:0];
    assign o_err  = (i_addr[1:0] != 2'b00) || (w_word >= c_depth);

endmodule : aes_addr_check
`default_nettype wire

// File: rtl/aes_bram_fetch.sv
`default_nettype none
// ============================================================================
// Module      : aes_bram_fetch
// Description : Word-read engine between the AES control FSM and the key/block
//               BRAM read port. 4-phase request/complete handshake, one BRAM
//               read per request, fixed read latency, address checking.
// Ports       : aes_clk / aes_rst     - clock, synchronous active-high reset
//               aes_start_read        - request level, held until complete
//               aes_bram_addr         - byte address, latched on acceptance
//               bram_complete         - read done, data/err valid while high
//               aes_bram_read_data    - returned word, held after completion
//               rd_err                - misaligned or out-of-range access
//               bram_en / bram_addr   - BRAM read enable pulse and word index
//               bram_rdata            - BRAM read data
//               rd_count              - completed reads, errors included
// Revision    : 1.0 - initial release
// ============================================================================
module aes_bram_fetch
    import aes_pkg::*;
#(
    parameter int          READ_LATENCY  = 2,
    parameter logic [31:0] BASE_ADDR     = c_def_base_addr,
    parameter int          DEPTH_WORDS   = c_def_depth_words,
    parameter int          IDX_W         = 10,
    // Reset value of rd_count; zero in normal use, nonzero only for bring-up
    parameter logic [15:0] RD_COUNT_INIT = 16'h0000
) (
    input  logic             aes_clk,
    input  logic             aes_rst,
    input  logic             aes_start_read,
    input  logic [31:0]      aes_bram_addr,
    output logic             bram_complete,
    output logic [31:0]      aes_bram_read_data,
    output logic             rd_err,
    output logic             bram_en,
    output logic [IDX_W-1:0] bram_addr,
    input  logic [31:0]      bram_rdata,
    output logic [15:0]      rd_count
);

    localparam logic [2:0] c_lat_load = 3'(READ_LATENCY - 1);

    state_t           r_state;
    logic             r_acc;        // request latched, check result due
    logic [31:0]      r_addr;
    logic [2:0]       r_lat_cnt;
    logic             r_complete;
    logic [31:0]      r_data;
    logic             r_err;
    logic             r_en;
    logic [IDX_W-1:0] r_bram_addr;
    logic [15:0]      r_count;

    logic [IDX_W-1:0] w_idx;
    logic             w_err;

    // Checking the latched address (not the live input) keeps the request
    // port off the BRAM address path; the decision is taken one cycle after
    // acceptance, which is what sets the request-to-complete latency.
    aes_addr_check #(
        .BASE_ADDR   (BASE_ADDR),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_addr_check (
        .i_addr (r_addr),
        .o_idx  (w_idx),
        .o_err  (w_err)
    );

    always_ff @(posedge aes_clk) begin
        if (aes_rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= 1'b0;
            r_addr      <= 32'h0;
            r_lat_cnt   <= 3'd0;
            r_complete  <= 1'b0;
            r_data      <= 32'h0;
            r_err       <= 1'b0;
            r_en        <= 1'b0;
            r_bram_addr <= '0;
            r_count     <= RD_COUNT_INIT;
        end else begin
            r_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_acc) begin
                        r_acc <= 1'b0;
                        if (w_err) begin
                            r_state    <= ST_DONE;
                            r_complete <= 1'b1;
                            r_err      <= 1'b1;
                            r_data     <= c_err_data;
                            r_count    <= r_count + 16'd1;
                        end else begin
                            r_state     <= ST_ISSUE;
                            r_en        <= 1'b1;
                            r_bram_addr <= w_idx;
                        end
                    end else if (aes_start_read) begin
                        r_addr <= aes_bram_addr;
                        r_acc  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    r_lat_cnt <= c_lat_load;
                    if (READ_LATENCY == 1) begin
                        // Single-cycle BRAM: data is valid on the ISSUE exit edge
                        r_state    <= ST_DONE;
                        r_complete <= 1'b1;
                        r_err      <= 1'b0;
                        r_data     <= bram_rdata;
                        r_count    <= r_count + 16'd1;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_lat_cnt <= r_lat_cnt - 3'd1;
                    if (r_lat_cnt == 3'd1) begin
                        r_state    <= ST_DONE;
                        r_complete <= 1'b1;
                        r_err      <= 1'b0;
                        r_data     <= bram_rdata;
                        r_count    <= r_count + 16'd1;
                    end
                end
                ST_DONE: begin
                    if (!aes_start_read) begin
                        r_state    <= ST_RTZ;
                        r_complete <= 1'b0;
                        r_err      <= 1'b0;
                    end
                end
                ST_RTZ: begin
                    // Requests are ignored here so complete stays low >= 1 cycle
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bram_complete      = r_complete;
    assign aes_bram_read_data = r_data;
    assign rd_err             = r_err;
    assign bram_en            = r_en;
    assign bram_addr          = r_bram_addr;
    assign rd_count           = r_count;

endmodule : aes_bram_fetch
`default_nettype wire

// File: tb/tb_aes_bram_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_bram_fetch
// Description : Self-checking bench for aes_bram_fetch. Three instances with
//               read latencies 2, 1 and 7 share clock and reset; each has its
//               own BRAM model. Expected results go through a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_bram_fetch;

    localparam int          N    = 3;
    localparam logic [31:0] BASE = 32'h0000_4000;
    localparam int          DEPTH = 1024;

    function automatic int lat_of(int k);
        case (k)
            1:       return 1;
            2:       return 7;
            default: return 2;
        endcase
    endfunction

    function automatic logic [15:0] init_of(int k);
        return (k == 1) ? 16'hFFFE : 16'h0000;
    endfunction

    function automatic logic [31:0] mem_word(logic [9:0] i);
        return {16'hA5A5, 6'h00, i};
    endfunction

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         start;
    logic [N-1:0][31:0]   addr;
    logic [N-1:0]         cmpl;
    logic [N-1:0]         err;
    logic [N-1:0]         en;
    logic [N-1:0][31:0]   data;
    logic [N-1:0][31:0]   rdata;
    logic [N-1:0][9:0]    baddr;
    logic [N-1:0][15:0]   cnt;

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_dut
        aes_bram_fetch #(
            .READ_LATENCY  (lat_of(k)),
            .BASE_ADDR     (BASE),
            .DEPTH_WORDS   (DEPTH),
            .IDX_W         (10),
            .RD_COUNT_INIT (init_of(k))
        ) u_dut (
            .aes_clk            (clk),
            .aes_rst            (rst),
            .aes_start_read     (start[k]),
            .aes_bram_addr      (addr[k]),
            .bram_complete      (cmpl[k]),
            .aes_bram_read_data (data[k]),
            .rd_err             (err[k]),
            .bram_en            (en[k]),
            .bram_addr          (baddr[k]),
            .bram_rdata         (rdata[k]),
            .rd_count           (cnt[k])
        );
    end

    // BRAM model: LAT-1 register stages after a combinational read, so data
    // for an access is valid just before the edge LAT cycles after ISSUE.
    logic [31:0] pipe [N][1:7];
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            pipe[k][1] <= en[k] ? mem_word(baddr[k]) : 32'hDEAD_BEEF;
            for (int j = 2; j <= 7; j++) pipe[k][j] <= pipe[k][j-1];
        end
    end
    always_comb begin
        rdata = '0;
        for (int k = 0; k < N; k++) begin
            if (lat_of(k) == 1)
                rdata[k] = en[k] ? mem_word(baddr[k]) : 32'hDEAD_BEEF;
            else
                rdata[k] = pipe[k][(lat_of(k) < 2) ? 1 : lat_of(k) - 1];
        end
    end

    // bram_en pulse monitor
    int         en_cnt [N];
    logic [9:0] en_idx [N];
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (en[k] === 1'b1) begin
                en_cnt[k] <= en_cnt[k] + 1;
                en_idx[k] <= baddr[k];
            end
        end
    end

    typedef struct {
        logic        err;
        logic [31:0] data;
        logic [9:0]  idx;
        int          lat;
    } exp_t;

    exp_t        sb [$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_cnt [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < N; k++) exp_cnt[k] = init_of(k);
    endtask

    // One full handshake on instance k. b2b: raised straight after the previous
    // completion fell (DUT still in RTZ). drop_early: release request in ISSUE.
    task automatic do_read(input int k, input logic [31:0] a, input bit b2b, input bit drop_early);
        exp_t        e;
        logic [31:0] off;
        int          i;
        int          en0;
        if (!b2b) begin
            @(posedge clk); #1;
        end
        off   = a - BASE;
        e.err = (a[1:0] != 2'b00) || ((off >> 2) >= 32'(DEPTH));
        e.idx = off[11:2];
        e.data = e.err ? 32'h0 : mem_word(e.idx);
        e.lat = (e.err ? 2 : 2 + lat_of(k)) + (b2b ? 1 : 0);
        sb.push_back(e);
        en0 = en_cnt[k];
        addr[k]  = a;
        start[k] = 1'b1;
        i = 0;
        while (cmpl[k] !== 1'b1 && i < 40) begin
            @(posedge clk); #1;
            i++;
            if (i == (b2b ? 2 : 1)) addr[k] = 32'h0000_0002;
            if (drop_early && i == 2) start[k] = 1'b0;
        end
        if (i >= 40) check("timeout", 32'(cmpl[k]), 32'h1);
        e = sb.pop_front();
        exp_cnt[k] = exp_cnt[k] + 16'd1;
        check("latency", 32'(i), 32'(e.lat));
        check("data", data[k], e.data);
        check("rd_err", 32'(err[k]), 32'(e.err));
        check("en_pulses", 32'(en_cnt[k] - en0), e.err ? 32'd0 : 32'd1);
        if (!e.err) check("bram_addr", 32'(en_idx[k]), 32'(e.idx));
        check("rd_count", 32'(cnt[k]), 32'(exp_cnt[k]));
        start[k] = 1'b0;
        @(posedge clk); #1;
        check("complete_low", 32'(cmpl[k]), 32'h0);
        check("err_low", 32'(err[k]), 32'h0);
        check("data_held", data[k], e.data);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   stale_ok;
        int   en0;
        start = '0;
        addr  = '0;
        rst   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < N; k++) exp_cnt[k] = init_of(k);

        // Reset state
        for (int k = 0; k < N; k++) begin
            check("rst_complete", 32'(cmpl[k]), 32'h0);
            check("rst_data", data[k], 32'h0);
            check("rst_err", 32'(err[k]), 32'h0);
            check("rst_en", 32'(en[k]), 32'h0);
            check("rst_baddr", 32'(baddr[k]), 32'h0);
            check("rst_count", 32'(cnt[k]), 32'(init_of(k)));
        end

        // Valid read, misaligned, out of range above and below the window
        do_read(0, BASE + 32'h10, 1'b0, 1'b0);
        do_read(0, BASE + 32'h6, 1'b0, 1'b0);
        do_read(0, BASE + 32'(4 * DEPTH), 1'b0, 1'b0);
        do_read(0, BASE - 32'h4, 1'b0, 1'b0);
        do_read(0, BASE + 32'(4 * DEPTH - 4), 1'b0, 1'b0);

        // Twelve back-to-back reads from a fresh count
        pulse_reset();
        for (int n = 0; n < 12; n++)
            do_read(0, BASE + 32'h100 + 32'(4 * n), n > 0, 1'b0);
        check("count12", 32'(cnt[0]), 32'd12);

        // Requester releases during ISSUE: access still completes
        do_read(0, BASE + 32'h20, 1'b0, 1'b1);

        // Latency 1 with counter wrap, latency 7
        do_read(1, BASE + 32'h8, 1'b0, 1'b0);
        do_read(1, BASE + 32'hC, 1'b1, 1'b0);
        check("count_wrap", 32'(cnt[1]), 32'h0);
        do_read(2, BASE + 32'h3FFC, 1'b0, 1'b0);
        do_read(2, BASE + 32'h4, 1'b0, 1'b0);

        // Reset while the latency-7 instance is in WAIT
        @(posedge clk); #1;
        en0 = en_cnt[2];
        addr[2]  = BASE + 32'h30;
        start[2] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("wait_en_seen", 32'(en_cnt[2] - en0), 32'd1);
        pulse_reset();
        start[2] = 1'b0;
        check("mid_rst_complete", 32'(cmpl[2]), 32'h0);
        check("mid_rst_data", data[2], 32'h0);
        check("mid_rst_count", 32'(cnt[2]), 32'h0);
        en0 = en_cnt[2];
        stale_ok = 1;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (cmpl[2] !== 1'b0 || data[2] !== 32'h0 || en[2] !== 1'b0) stale_ok = 0;
        end
        check("no_stale_capture", 32'(stale_ok), 32'd1);
        check("no_en_after_rst", 32'(en_cnt[2] - en0), 32'd0);
        do_read(2, BASE + 32'h44, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_aes_bram_fetch
`default_nettype wire
